pcileech_com_txarb: RTL and testbench

PCILEECH_COM_TXARB -- requirements
Module: pcileech_com_txarb

---
 rtl/pcileech_com_txarb.sv | 119 +++++++++++
 tb/tb_pcileech_com_txarb.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pcileech_com_txarb.sv
// pcileech_com_txarb: multi-requester TX arbiter feeding the com TX buffer.
// Arbitration is round-robin and happens in IDLE. A grant is held for a whole
// packet, which ends at req_last or at MAX_BURST words; the burst limit sets a
// sticky overrun error. Output words are registered, so each word appears one
// cycle after it is accepted.
// Optional build macro: COM_TXARB_PRIO0_EN gives requester 0 strict priority
// in IDLE arbitration. When it is undefined, all requesters are round-robin.
module pcileech_com_txarb #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 64,
  localparam int GW = $clog2(NUM_REQ),
  localparam int CW = $clog2(MAX_BURST)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_data,
  input  logic [NUM_REQ-1:0]     req_last,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [31:0]            out_data,
  output logic                   out_wr_en,
  input  logic                   out_ready,
  output logic [GW-1:0]          grant_id,
  output logic                   busy,
  output logic                   err_overrun
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_BURST = 1'b1;

  logic [0:0]    r_state;
  logic [GW-1:0] r_grant_id;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_out_data;
  logic          r_out_wr_en;
  logic          r_err;

  logic [GW-1:0] w_arb_id;
  logic          w_any_valid;
  logic          w_sel_valid;
  logic          w_sel_last;
  logic [31:0]   w_sel_data;
  logic          w_xfer;

  assign w_any_valid = |req_valid;
  assign w_sel_valid = req_valid[r_grant_id];
  assign w_sel_last  = req_last[r_grant_id];
  assign w_sel_data  = req_data[32*r_grant_id +: 32];
  assign w_xfer      = (r_state == S_BURST) && w_sel_valid && out_ready;

  // Round-robin pick: first valid requester after the last grant.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves it unassigned and no latch is inferred.
    w_arb_id = r_grant_id;
    for (int k = NUM_REQ; k >= 1; k--) begin
      // Scanning from the far end lets the nearest valid requester win last.
      int idx;
      idx = (int'(r_grant_id) + k) % NUM_REQ;
      if (req_valid[idx]) w_arb_id = GW'(idx);
    end
`ifdef COM_TXARB_PRIO0_EN
    if (req_valid[0]) w_arb_id = '0;
`endif
  end

  // Only the granted requester sees backpressure-driven ready during a burst.
  always_comb begin
    req_ready = '0;
    if (r_state == S_BURST) req_ready[r_grant_id] = out_ready;
  end

  // FSM, grant, burst counter, output register and sticky error.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant_id  <= GW'(NUM_REQ - 1);
      r_cnt       <= '0;
      r_out_data  <= '0;
      r_out_wr_en <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_valid) begin
            r_grant_id <= w_arb_id;
            r_cnt      <= '0;
            r_state    <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_xfer) begin
            r_out_data  <= w_sel_data;
            r_out_wr_en <= 1'b1;
            r_cnt       <= r_cnt + 1'b1;
            if (w_sel_last) begin
              r_state <= S_IDLE;
            end else if (r_cnt == CW'(MAX_BURST - 1)) begin
              // Burst limit reached without an end marker: drop the grant.
              r_err   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_data    = r_out_data;
  assign out_wr_en   = r_out_wr_en;
  assign grant_id    = r_grant_id;
  assign busy        = (r_state == S_BURST);
  assign err_overrun = r_err;

endmodule

// File: tb/tb_pcileech_com_txarb.sv
// Directed bench for pcileech_com_txarb (NUM_REQ=3, MAX_BURST=4).
// Requesters are modelled as word queues; every expected value is hand-derived.
module tb_pcileech_com_txarb;

  localparam int NR = 3;
  localparam int MB = 4;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req_valid;
  logic [32*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [31:0]     out_data;
  logic            out_wr_en;
  logic            out_ready;
  logic [1:0]      grant_id;
  logic            busy;
  logic            err_overrun;

  pcileech_com_txarb #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .out_data   (out_data),
    .out_wr_en  (out_wr_en),
    .out_ready  (out_ready),
    .grant_id   (grant_id),
    .busy       (busy),
    .err_overrun(err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester queues: bit 32 is the last flag.
  logic [32:0] q [NR][$];

  logic        rst_seq  [16];
  logic        ordy_seq [16];
  logic        wr_log   [16];
  logic [31:0] data_log [16];
  logic [1:0]  gid_log  [16];
  logic        busy_log [16];
  logic        err_log  [16];
  logic [NR-1:0] rdy_log [16];

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [32:0] w;
    for (int i = 0; i < NR; i++) begin
      if (q[i].size() > 0) begin
        w = q[i][0];
        req_valid[i]         = 1'b1;
        req_data[32*i +: 32] = w[31:0];
        req_last[i]          = w[32];
      end else begin
        req_valid[i]         = 1'b0;
        req_data[32*i +: 32] = '0;
        req_last[i]          = 1'b0;
      end
    end
  endtask

  task automatic prep();
    for (int k = 0; k < 16; k++) begin
      rst_seq[k]  = 1'b0;
      ordy_seq[k] = 1'b1;
    end
  endtask

  task automatic apply_reset();
    for (int i = 0; i < NR; i++) q[i].delete();
    rst = 1'b1;
    out_ready = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Runs n cycles; logs outputs mid-cycle and pops accepted words at the edge.
  task automatic run(input int n);
    logic [NR-1:0] hs;
    for (int k = 0; k < n; k++) begin
      rst       = rst_seq[k];
      out_ready = ordy_seq[k];
      drive();
      #1;
      wr_log[k]   = out_wr_en;
      data_log[k] = out_data;
      gid_log[k]  = grant_id;
      busy_log[k] = busy;
      err_log[k]  = err_overrun;
      rdy_log[k]  = req_ready;
      hs = req_valid & req_ready & {NR{~rst}};
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) if (hs[i]) void'(q[i].pop_front());
    end
  endtask

  int          e1_wr   [16] = '{0,0,1,1,0,1,1,0,1,1,0,1,1,0,1,1};
  logic [31:0] e1_data [16] = '{0,0,32'h1000,32'h1001,0,32'h1010,32'h1011,0,
                                32'h1020,32'h1021,0,32'h1002,32'h1003,0,32'h1012,32'h1013};
  int          e2_wr   [8]  = '{0,0,1,0,1,1,1,0};
  logic [31:0] e2_data [8]  = '{0,0,32'hA0,32'hA0,32'hA1,32'hA2,32'hA3,32'hA3};
  int          e2_rdy  [8]  = '{0,2,0,2,2,2,0,0};
  int          e3_wr   [8]  = '{0,0,1,1,1,1,0,1};
  logic [31:0] e3_data [8]  = '{0,0,32'hB0,32'hB1,32'hB2,32'hB3,32'hB3,32'hC0};
  int          e3_err  [8]  = '{0,0,0,0,0,1,1,1};

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    out_ready = 1'b1;

    // Reset state.
    apply_reset();
    check("rst wr_en", 32'(out_wr_en), 0);
    check("rst data", out_data, 0);
    check("rst busy", 32'(busy), 0);
    check("rst err", 32'(err_overrun), 0);
    check("rst grant", 32'(grant_id), NR - 1);
    check("rst ready", 32'(req_ready), 0);

    // All three requesters valid, 2-word packets: grants 0,1,2,0,1.
    for (int i = 0; i < NR; i++) begin
      q[i].push_back({1'b0, 32'h1000 + 32'(16*i)});
      q[i].push_back({1'b1, 32'h1001 + 32'(16*i)});
    end
    q[0].push_back({1'b0, 32'h1002});
    q[0].push_back({1'b1, 32'h1003});
    q[1].push_back({1'b0, 32'h1012});
    q[1].push_back({1'b1, 32'h1013});
    prep();
    run(16);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("rr wr[%0d]", k), 32'(wr_log[k]), 32'(e1_wr[k]));
      if (e1_wr[k] != 0) check($sformatf("rr data[%0d]", k), data_log[k], e1_data[k]);
    end
    check("rr idle busy", 32'(busy_log[0]), 0);
    check("rr latency busy", 32'(busy_log[1]), 1);
    check("rr gap busy", 32'(busy_log[3]), 0);
    check("rr grant a", 32'(gid_log[1]), 0);
    check("rr grant b", 32'(gid_log[4]), 1);
    check("rr grant c", 32'(gid_log[7]), 2);
    check("rr grant d", 32'(gid_log[10]), 0);
    check("rr grant e", 32'(gid_log[13]), 1);

    // Requester 1, 4 words, out_ready low on the second burst cycle.
    apply_reset();
    for (int j = 0; j < 4; j++) q[1].push_back({(j == 3), 32'hA0 + 32'(j)});
    prep();
    ordy_seq[2] = 1'b0;
    run(8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("stall wr[%0d]", k), 32'(wr_log[k]), 32'(e2_wr[k]));
      check($sformatf("stall data[%0d]", k), data_log[k], e2_data[k]);
      check($sformatf("stall ready[%0d]", k), 32'(rdy_log[k]), 32'(e2_rdy[k]));
    end
    check("stall busy", 32'(busy_log[2]), 1);
    check("stall grant", 32'(gid_log[2]), 1);

    // Overrun: requester 2 sends 6 words with no end marker, requester 0 waits.
    for (int j = 0; j < 6; j++) q[2].push_back({1'b0, 32'hB0 + 32'(j)});
    q[0].push_back({1'b1, 32'hC0});
    prep();
    run(8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ovr wr[%0d]", k), 32'(wr_log[k]), 32'(e3_wr[k]));
      if (e3_wr[k] != 0) check($sformatf("ovr data[%0d]", k), data_log[k], e3_data[k]);
      check($sformatf("ovr err[%0d]", k), 32'(err_log[k]), 32'(e3_err[k]));
    end
    check("ovr grant first", 32'(gid_log[1]), 2);
    check("ovr busy last word", 32'(busy_log[4]), 1);
    check("ovr idle after limit", 32'(busy_log[5]), 0);
    check("ovr grant passes", 32'(gid_log[6]), 0);

    // Reset in the middle of a 5-word packet.
    apply_reset();
    for (int j = 0; j < 5; j++) q[0].push_back({(j == 4), 32'hD0 + 32'(j)});
    prep();
    rst_seq[3] = 1'b1;
    run(6);
    check("mrst wr before", 32'(wr_log[3]), 1);
    check("mrst data before", data_log[3], 32'hD1);
    check("mrst wr after", 32'(wr_log[4]), 0);
    check("mrst wr after2", 32'(wr_log[5]), 0);
    check("mrst busy", 32'(busy_log[4]), 0);
    check("mrst grant", 32'(gid_log[4]), NR - 1);
    check("mrst data", data_log[4], 0);

    // Requesters 0 and 1 continuously valid with single-word packets.
    apply_reset();
    for (int j = 0; j < 4; j++) begin
      q[0].push_back({1'b1, 32'hE0 + 32'(j)});
      q[1].push_back({1'b1, 32'hF0 + 32'(j)});
    end
    prep();
    run(9);
`ifdef COM_TXARB_PRIO0_EN
    check("prio grant a", 32'(gid_log[1]), 0);
    check("prio grant b", 32'(gid_log[3]), 0);
    check("prio grant c", 32'(gid_log[5]), 0);
    check("prio grant d", 32'(gid_log[7]), 0);
    check("prio data a", data_log[2], 32'hE0);
    check("prio data b", data_log[4], 32'hE1);
    check("prio data c", data_log[6], 32'hE2);
    check("prio data d", data_log[8], 32'hE3);
`else
    check("alt grant a", 32'(gid_log[1]), 0);
    check("alt grant b", 32'(gid_log[3]), 1);
    check("alt grant c", 32'(gid_log[5]), 0);
    check("alt grant d", 32'(gid_log[7]), 1);
    check("alt data a", data_log[2], 32'hE0);
    check("alt data b", data_log[4], 32'hF0);
    check("alt data c", data_log[6], 32'hE1);
    check("alt data d", data_log[8], 32'hF1);
`endif
    check("single wr a", 32'(wr_log[2]), 1);
    check("single gap", 32'(wr_log[3]), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
